// File: rtl/spi_cfg_master.sv
// spi_cfg_master: SPI mode-0 master sending a 48-bit Freq/WaveSet/Amp frame MSB first.
// Define SPI_CRC8_EN to append a CRC-8 (poly 0x07) byte, making the frame 56 bits.
module spi_cfg_master #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [23:0] Freq_in,
  input  logic [7:0]  WaveSet_in,
  input  logic [15:0] Amp_in,
  output logic        busy,
  output logic        done,
  output logic [7:0]  rx_status,
  output logic        SPI_SCK,
  output logic        SPI_SS,
  output logic        SPI_MOSI,
  input  logic        SPI_MISO
);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;
  logic [47:0] w_payload;
  assign w_payload = {Freq_in, WaveSet_in, Amp_in};
`ifdef SPI_CRC8_EN
  localparam int N = 56;
  function automatic logic [7:0] crc8(input logic [47:0] d);
    logic [7:0] c;
    c = '0;
    for (int i = 47; i >= 0; i--) c = {c[6:0], 1'b0} ^ ((c[7] ^ d[i]) ? 8'h07 : 8'h00);
    return c;
  endfunction
  logic [N-1:0] w_frame;
  assign w_frame = {w_payload, crc8(w_payload)};
`else
  localparam int N = 48;
  logic [N-1:0] w_frame;
  assign w_frame = w_payload;
`endif
  state_t       r_state, w_next;
  logic [7:0]   r_div;
  logic [5:0]   r_bits;
  logic [N-1:0] r_tx;
  logic [7:0]   r_rx;
  logic         r_sck;
  logic         w_tick, w_last;
  assign w_tick   = r_div == 8'(CLK_DIV - 1);
  assign w_last   = r_bits == 6'(N);
  assign SPI_SCK  = r_sck;
  assign SPI_MOSI = r_tx[N-1];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    busy   = 1'b1;
    done   = 1'b0;
    SPI_SS = 1'b0;
    case (r_state)
      IDLE: begin
        busy   = 1'b0;
        SPI_SS = 1'b1;
        w_next = start ? SETUP : IDLE;
      end
      SETUP: w_next = w_tick ? SHIFT : SETUP;
      SHIFT: w_next = (w_tick && r_sck && w_last) ? HOLD : SHIFT;
      HOLD:  w_next = w_tick ? DONE : HOLD;
      DONE: begin
        done   = 1'b1;
        SPI_SS = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end
  // Rising SCK samples MISO and counts the bit; falling SCK shifts MOSI except after the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div     <= '0;
      r_bits    <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_sck     <= 1'b0;
      rx_status <= '0;
    end else begin
      r_div <= (r_state == IDLE || r_state == DONE || w_tick) ? '0 : r_div + 8'd1;
      if (r_state == IDLE && start) begin
        r_tx   <= w_frame;
        r_bits <= '0;
      end
      if (r_state == SHIFT && w_tick) begin
        r_sck <= ~r_sck;
        if (!r_sck) begin
          r_bits <= r_bits + 6'd1;
          r_rx   <= {r_rx[6:0], SPI_MISO};
        end else if (!w_last) r_tx <= {r_tx[N-2:0], 1'b0};
      end
      if (r_state == HOLD && w_tick) rx_status <= r_rx;
    end
  end
endmodule

// File: tb/tb_spi_cfg_master.sv
// tb_spi_cfg_master: directed and randomized frames checked against a frame-level model.
module tb_spi_cfg_master;
`ifdef SPI_CRC8_EN
  localparam int N = 56;
`else
  localparam int N = 48;
`endif
  localparam int D = 4;
  localparam logic [63:0] MASK = (64'd1 << N) - 64'd1;
  logic        clk = 1'b0, rst_n = 1'b1, start = 1'b0;
  logic [23:0] Freq_in = '0;
  logic [7:0]  WaveSet_in = '0;
  logic [15:0] Amp_in = '0;
  logic        busy, done, SPI_SCK, SPI_SS, SPI_MOSI, SPI_MISO;
  logic [7:0]  rx_status;
  int checks = 0, errors = 0;
  int rises = 0, fr_rises = 0, ss_low = 0, done_cnt = 0;
  logic [63:0] cap = '0, miso_word = '0;
  logic        prev_sck = 1'b0;
  logic [63:0] exp_f, exp_m;
  int b_rises, b_ss, b_done;

  spi_cfg_master #(.CLK_DIV(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .Freq_in(Freq_in), .WaveSet_in(WaveSet_in),
    .Amp_in(Amp_in), .busy(busy), .done(done), .rx_status(rx_status), .SPI_SCK(SPI_SCK),
    .SPI_SS(SPI_SS), .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO)
  );

  always #5 clk = ~clk;
  assign SPI_MISO = (fr_rises < N) ? miso_word[N-1-fr_rises] : 1'b0;

  // Slave/observer: records MOSI at every SCK rise and counts SS-low cycles and done pulses.
  always @(negedge clk) begin
    if (SPI_SCK && !prev_sck) begin
      cap   <= {cap[62:0], SPI_MOSI};
      rises <= rises + 1;
    end
    fr_rises <= SPI_SS ? 0 : fr_rises + ((SPI_SCK && !prev_sck) ? 1 : 0);
    prev_sck <= SPI_SCK;
    if (!SPI_SS) ss_low <= ss_low + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  function automatic logic [63:0] model(input logic [23:0] f, input logic [7:0] w, input logic [15:0] a);
    logic [47:0] p;
`ifdef SPI_CRC8_EN
    logic [7:0] c;
    p = {f, w, a};
    c = 8'h00;
    for (int b = 5; b >= 0; b--) begin
      c ^= p[b*8 +: 8];
      for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return {8'h00, p, c};
`else
    p = {f, w, a};
    return {16'h0000, p};
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [23:0] f, input logic [7:0] w, input logic [15:0] a, input logic [63:0] mw);
    @(negedge clk);
    Freq_in = f; WaveSet_in = w; Amp_in = a; miso_word = mw; start = 1'b1;
    exp_f = model(f, w, a); exp_m = mw;
    b_rises = rises; b_ss = ss_low; b_done = done_cnt;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("ss_after_start", SPI_SS, 0);
    chk("mosi_first_bit", SPI_MOSI, exp_f[N-1]);
  endtask

  task automatic wait_done(output logic got);
    got = 1'b0;
    for (int i = 0; i < (2*N+4)*D + 50 && !got; i++) begin
      @(negedge clk);
      got = done;
    end
  endtask

  task automatic wait_rises(input int n);
    for (int i = 0; i < (2*N+4)*D + 50 && (rises - b_rises) < n; i++) @(negedge clk);
    chk("rise_reached", 64'((rises - b_rises) >= n), 1);
  endtask

  task automatic finish(input string tag);
    logic got;
    wait_done(got);
    chk({tag, ":done_seen"}, got, 1);
    chk({tag, ":rx_at_done"}, rx_status, exp_m[7:0]);
    @(negedge clk);
    chk({tag, ":busy_after_done"}, busy, 0);
    chk({tag, ":done_one_cycle"}, done, 0);
    @(negedge clk);
    chk({tag, ":frame"}, cap & MASK, exp_f);
    chk({tag, ":sck_rises"}, rises - b_rises, N);
    chk({tag, ":ss_low_cycles"}, ss_low - b_ss, (2*N+2)*D);
    chk({tag, ":done_count"}, done_cnt - b_done, 1);
  endtask

  initial begin
    logic [7:0] prev_rx;
    logic got, ss_ok;
    int bd, idle;
    #1 rst_n = 1'b0;
    #3;
    chk("rst_ss", SPI_SS, 1); chk("rst_sck", SPI_SCK, 0); chk("rst_mosi", SPI_MOSI, 0);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_rx", rx_status, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    launch(24'h123456, 8'h02, 16'hABCD, {32'($urandom), 24'($urandom), 8'hA5});
    finish("basic");
`ifndef SPI_CRC8_EN
    chk("basic:literal_frame", cap & MASK, 64'h12345602ABCD);
`endif
    repeat (20) @(negedge clk);
    chk("rx_held_idle", rx_status, 8'hA5);
    for (int i = 0; i < 3; i++) begin
      launch(24'($urandom), 8'($urandom), 16'($urandom), {32'($urandom), 32'($urandom)});
      finish("random");
    end
    prev_rx = exp_m[7:0];
    launch(24'($urandom), 8'($urandom), 16'($urandom), {32'($urandom), 32'($urandom)});
    wait_rises(20);
    chk("rx_unchanged_midframe", rx_status, prev_rx);
    @(negedge clk);
    Freq_in = ~Freq_in; Amp_in = ~Amp_in; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish("ignored_start");
    launch(24'($urandom), 8'($urandom), 16'($urandom), {32'($urandom), 32'($urandom)});
    wait_rises(30);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_ss", SPI_SS, 1); chk("abort_sck", SPI_SCK, 0); chk("abort_busy", busy, 0);
    chk("abort_mosi", SPI_MOSI, 0); chk("abort_rx", rx_status, 0);
    bd = done_cnt;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_no_done", done_cnt - bd, 0);
    launch(24'($urandom), 8'($urandom), 16'($urandom), {32'($urandom), 32'($urandom)});
    finish("after_abort");
`ifdef SPI_CRC8_EN
    launch(24'h000000, 8'h00, 16'h0001, {32'($urandom), 32'($urandom)});
    finish("crc_one");
    chk("crc_one_byte", cap[7:0], 8'h07);
    launch(24'h000000, 8'h00, 16'h0000, {32'($urandom), 32'($urandom)});
    finish("crc_zero");
    chk("crc_zero_byte", cap[7:0], 8'h00);
`endif
    @(negedge clk);
    Freq_in = 24'($urandom); WaveSet_in = 8'($urandom); Amp_in = 16'($urandom);
    miso_word = {32'($urandom), 32'($urandom)};
    exp_f = model(Freq_in, WaveSet_in, Amp_in); exp_m = miso_word;
    start = 1'b1;
    for (int f = 0; f < 3; f++) begin
      wait_done(got);
      chk("b2b_done_seen", got, 1);
      chk("b2b_frame", cap & MASK, exp_f);
      chk("b2b_rx", rx_status, exp_m[7:0]);
      idle = 0; ss_ok = 1'b1;
      @(negedge clk);
      while (!busy && idle < 10) begin
        ss_ok &= SPI_SS;
        idle++;
        @(negedge clk);
      end
      chk("b2b_idle_cycles", idle, 1);
      chk("b2b_idle_ss", ss_ok, 1);
    end
    start = 1'b0;
    wait_done(got);
    chk("b2b_last_done", got, 1);
    repeat (3) @(negedge clk);
    chk("final_idle_busy", busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_cfg_master.md
SPI_CFG_MASTER -- requirements
Module: spi_cfg_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: SCK half-period in clk cycles, legal range 2..255.
REQ-002 SHALL have port clk, input, 1 bit: single system clock; all logic is on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: single-cycle frame request.
REQ-005 SHALL have port Freq_in, input, 24 bits: frequency word to transmit.
REQ-006 SHALL have port WaveSet_in, input, 8 bits: waveform select to transmit.
REQ-007 SHALL have port Amp_in, input, 16 bits: amplitude word to transmit.
REQ-008 SHALL have port busy, output, 1 bit: high while a frame is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse at frame end.
REQ-010 SHALL have port rx_status, output, 8 bits: last 8 MISO bits of the most recent frame.
REQ-011 SHALL have port SPI_SCK, output, 1 bit: serial clock, mode 0 (CPOL=0, CPHA=0).
REQ-012 SHALL have port SPI_SS, output, 1 bit: active-low slave select.
REQ-013 SHALL have port SPI_MOSI, output, 1 bit: serial data out, MSB first.
REQ-014 SHALL have port SPI_MISO, input, 1 bit: serial data in.

Function
REQ-015 SHALL implement the frame payload as Freq_in, WaveSet_in, Amp_in in that order, 48 bits total, MSB first; this is the same layout the FPGA slave decodes.
REQ-016 SHALL implement the FSM as IDLE -> SETUP -> SHIFT -> HOLD -> DONE -> IDLE.
REQ-017 SHALL, in IDLE, accept start only when busy=0 and latch all three payload inputs in that cycle; start SHALL be ignored in every other state.
REQ-018 SHALL, on the cycle after start is accepted, drive SPI_SS=0 and busy=1, and set SPI_MOSI to payload bit 47.
REQ-019 SHALL hold the SETUP state for CLK_DIV cycles with SPI_SCK=0.
REQ-020 SHALL, in SHIFT, toggle SPI_SCK every CLK_DIV cycles; it SHALL sample SPI_MISO on each SCK rising edge and advance SPI_MOSI on each SCK falling edge, except the last falling edge.
REQ-021 SHALL leave SHIFT on the falling edge that follows the Nth rising edge, where N is the frame bit count.
REQ-022 SHALL hold the HOLD state for CLK_DIV cycles with SPI_SCK=0 and SPI_SS=0.
REQ-023 SHALL, in DONE (one cycle), drive SPI_SS=1, pulse done=1, update rx_status with the last 8 sampled MISO bits, and drop busy to 0 on the following cycle.
REQ-024 SHALL implement the bit counter so it never wraps: exactly N SCK rising edges per frame.
REQ-025 SHALL keep SPI_SS low for exactly 2*CLK_DIV + 2*CLK_DIV*N clk cycles.
REQ-026 SHALL allow a new start to be accepted on the first cycle after busy falls; if start is high in that same cycle, it SHALL launch a new frame.
REQ-027 SHALL keep SPI_MOSI stable at the last driven bit while idle.

Reset
REQ-028 SHALL, while rst_n=0, immediately force: SPI_SS=1, SPI_SCK=0, SPI_MOSI=0, busy=0, done=0, rx_status=0x00, state=IDLE, all counters and shift registers cleared.
REQ-029 SHALL, on reset asserted mid-frame, abort the frame with no done pulse; the first frame after release SHALL start cleanly from SETUP.

Configuration
REQ-030 SHALL, when SPI_CRC8_EN is defined, append a CRC-8 (polynomial 0x07, init 0x00, no reflection, no final XOR) computed over the 48 payload bits, giving N=56.
REQ-031 SHALL, when SPI_CRC8_EN is not defined, use N=48 and include no CRC logic.

Verification
REQ-032 SHALL verify, with CLK_DIV=4, start and payload 0x123456/0x02/0xABCD: MOSI serialises 0x12345602ABCD, with 48 SCK rises, SS low for 392 cycles, and one done pulse.
REQ-033 SHALL verify a slave driving MISO so the last byte is 0xA5: rx_status=0xA5 at done, and rx_status unchanged until the next done.
REQ-034 SHALL verify start pulsed again at mid-frame bit 20: the second start is ignored, and the first frame completes unaltered.
REQ-035 SHALL verify rst_n=0 asserted at bit 30: SS=1, SCK=0, busy=0 combinationally, with no done; a subsequent frame completes correctly.
REQ-036 SHALL verify, with SPI_CRC8_EN and payload 0x000000/0x00/0x0001: a 56-bit frame whose final byte is 0x07; with an all-zero payload, the final byte is 0x00.
REQ-037 SHALL verify start held high continuously: back-to-back frames, each separated by exactly one idle cycle with SS=1.
